// File: rtl/audio_sample_fifo.sv
// Sample FIFO between the CPU IO bus and the HDMI audio port. A phase accumulator
// paces pops at RATE_HZ; an empty FIFO repeats the last sample and flags underrun.
module audio_sample_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int CLK_HZ     = 74250000,
  parameter int RATE_HZ    = 48000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_wr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_clr_flags,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_underrun,
  output logic                  o_overflow,
  output logic                  o_audio_w,
  output logic [31:0]           o_audio
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [31:0] IncPos = 32'(RATE_HZ);
  localparam logic [31:0] IncNeg = 32'(RATE_HZ - CLK_HZ);
  localparam logic [DEPTH_LOG2:0] LvlFull = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LvlOne  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PtrOne = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [31:0]           r_mem [Depth];
  logic [31:0]           r_d;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_full;
  logic                  r_underrun;
  logic                  r_overflow;
  logic                  r_audio_w;
  logic [31:0]           r_audio;

  logic                  w_tick;
  logic                  w_pop_req;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic [DEPTH_LOG2:0]   w_level_d;

  assign w_tick    = ~r_d[31];
  assign w_pop_req = w_tick & i_enable;
  assign w_empty   = (r_level == '0);
  assign w_pop     = w_pop_req & ~w_empty;
  // Full is judged on the registered state, so a same-cycle pop never frees a slot for a write.
  assign w_push    = i_wr & ~r_full;

  always_comb begin
    w_level_d = r_level;
    if (w_push && !w_pop) begin
      w_level_d = r_level + LvlOne;
    end else if (w_pop && !w_push) begin
      w_level_d = r_level - LvlOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_d        <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_audio_w  <= 1'b0;
      r_audio    <= '0;
    end else begin
      r_d        <= r_d + (r_d[31] ? IncPos : IncNeg);
      r_level    <= w_level_d;
      r_full     <= (w_level_d == LvlFull);
      r_audio_w  <= w_pop_req;
      r_underrun <= (w_pop_req & w_empty) | (r_underrun & ~i_clr_flags);
      r_overflow <= (i_wr & r_full) | (r_overflow & ~i_clr_flags);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
        r_audio  <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_full     = r_full;
  assign o_level    = r_level;
  assign o_underrun = r_underrun;
  assign o_overflow = r_overflow;
  assign o_audio_w  = r_audio_w;
  assign o_audio    = r_audio;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: a queue model predicts every strobe, level and flag,
// with directed checks for rate, ordering, underrun, overflow, coincident events and reset.
module tb_audio_sample_fifo;

  localparam int DepthLog2 = 2;
  localparam int Depth     = 4;
  localparam int ClkHz     = 100;
  localparam int RateHz    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              wr  = 1'b0;
  logic              clr = 1'b0;
  logic [31:0]       wdata = '0;
  logic              o_full;
  logic [DepthLog2:0] o_level;
  logic              o_underrun;
  logic              o_overflow;
  logic              o_audio_w;
  logic [31:0]       o_audio;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_d      = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_audio  = '0;
  bit          m_aw     = 1'b0;
  bit          m_under  = 1'b0;
  bit          m_over   = 1'b0;
  int          cyc      = 0;
  int          n_strobes = 0;
  bit          rec_on   = 1'b0;
  int          rec[$];
  int          exp_cyc[5] = '{1, 35, 68, 101, 135};
  logic [31:0] ord_vals[3] = '{32'h22221111, 32'h44443333, 32'h66665555};

  audio_sample_fifo #(
    .DEPTH_LOG2 (DepthLog2),
    .CLK_HZ     (ClkHz),
    .RATE_HZ    (RateHz)
  ) u_dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_wr        (wr),
    .i_wdata     (wdata),
    .i_clr_flags (clr),
    .o_full      (o_full),
    .o_level     (o_level),
    .o_underrun  (o_underrun),
    .o_overflow  (o_overflow),
    .o_audio_w   (o_audio_w),
    .o_audio     (o_audio)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance one clock: update the model from the inputs held over this edge, then compare.
  task automatic step();
    bit tick;
    bit set_u;
    bit set_o;
    int pre;
    if (rst) begin
      m_d = 0;
      m_q.delete();
      m_audio = '0;
      m_aw = 1'b0;
      m_under = 1'b0;
      m_over = 1'b0;
    end else begin
      tick  = (m_d >= 0);
      m_d   = m_d + ((m_d < 0) ? RateHz : (RateHz - ClkHz));
      m_aw  = tick && en;
      set_u = 1'b0;
      set_o = 1'b0;
      pre   = m_q.size();
      if (m_aw) begin
        if (pre > 0) m_audio = m_q.pop_front();
        else set_u = 1'b1;
      end
      if (wr) begin
        if (pre < Depth) m_q.push_back(wdata);
        else set_o = 1'b1;
      end
      if (clr) begin
        m_under = 1'b0;
        m_over  = 1'b0;
      end
      if (set_u) m_under = 1'b1;
      if (set_o) m_over = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else cyc++;
    if (m_aw) n_strobes++;
    if (rec_on && o_audio_w) rec.push_back(cyc);
    check_eq("sb_audio_w", o_audio_w, m_aw);
    check_eq("sb_audio", o_audio, m_audio);
    check_eq("sb_level", o_level, m_q.size());
    check_eq("sb_full", o_full, m_q.size() == Depth);
    check_eq("sb_underrun", o_underrun, m_under);
    check_eq("sb_overflow", o_overflow, m_over);
  endtask

  task automatic wait_strobes(input int n);
    int target;
    target = n_strobes + n;
    for (int i = 0; i < 400 && n_strobes < target; i++) step();
    check_eq("strobe_wait", n_strobes, target);
  endtask

  // Stop in a cycle whose tick will fire at the coming edge.
  task automatic wait_tick();
    for (int i = 0; i < 200 && m_d < 0; i++) step();
    check_eq("tick_wait", m_d >= 0, 1);
  endtask

  task automatic write(input logic [31:0] data);
    wr = 1'b1;
    wdata = data;
    step();
    wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check_eq("rst_level", o_level, 0);
    check_eq("rst_full", o_full, 0);
    check_eq("rst_audio_w", o_audio_w, 0);
    check_eq("rst_audio", o_audio, 0);
    check_eq("rst_flags", {o_underrun, o_overflow}, 0);

    // Rate and underrun on an empty FIFO
    rst = 1'b0;
    en  = 1'b1;
    rec_on = 1'b1;
    step();
    check_eq("first_strobe", o_audio_w, 1);
    check_eq("underrun_set", o_underrun, 1);
    check_eq("underrun_audio", o_audio, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("underrun_clr", o_underrun, 0);
    while (cyc < 140) step();
    rec_on = 1'b0;
    check_eq("rate_count", rec.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < rec.size()) check_eq("rate_cycle", rec[i], exp_cyc[i]);
    end

    // Ordering
    for (int i = 0; i < 3; i++) write(ord_vals[i]);
    check_eq("ord_level3", o_level, 3);
    for (int i = 0; i < 3; i++) begin
      wait_strobes(1);
      check_eq("ord_value", o_audio, ord_vals[i]);
    end
    check_eq("ord_level0", o_level, 0);

    // Full / overflow with output gated off
    en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) write(32'hA000_0000 + 32'(i));
    check_eq("full_flag", o_full, 1);
    check_eq("full_level", o_level, 4);
    check_eq("full_overflow", o_overflow, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("overflow_clr", o_overflow, 0);
    wait_tick();
    en = 1'b1;
    wr = 1'b1;
    wdata = 32'hDEAD_BEEF;
    step();
    wr = 1'b0;
    check_eq("fullpop_level", o_level, 3);
    check_eq("fullpop_overflow", o_overflow, 1);
    check_eq("fullpop_audio", o_audio, 32'hA000_0000);
    wait_strobes(3);
    check_eq("drain_last", o_audio, 32'hA000_0003);
    wait_strobes(1);
    check_eq("drain_underrun", o_underrun, 1);
    check_eq("drain_repeat", o_audio, 32'hA000_0003);
    check_eq("drain_level", o_level, 0);

    // Write coincident with a tick on an empty FIFO
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("sim_clr", o_underrun, 0);
    wait_tick();
    write(32'h5555_AAAA);
    check_eq("sim_underrun", o_underrun, 1);
    check_eq("sim_level", o_level, 1);
    check_eq("sim_repeat", o_audio, 32'hA000_0003);
    wait_strobes(1);
    check_eq("sim_next", o_audio, 32'h5555_AAAA);
    check_eq("sim_level0", o_level, 0);

    // Reset mid-stream
    write(32'hB000_0001);
    write(32'hB000_0002);
    check_eq("mid_level2", o_level, 2);
    rst = 1'b1;
    step();
    check_eq("mid_rst_level", o_level, 0);
    check_eq("mid_rst_audio", o_audio, 0);
    check_eq("mid_rst_audio_w", o_audio_w, 0);
    check_eq("mid_rst_flags", {o_underrun, o_overflow, o_full}, 0);
    rst = 1'b0;
    step();
    check_eq("mid_release_tick", o_audio_w, 1);
    check_eq("mid_release_underrun", o_underrun, 1);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
